edge_detect: RTL and testbench

Registered boundary and contact detector for the pong game-logic domain. Each cycle it takes the geometry of the ball and both paddles (size, initial position, offset) and reports which of their sides touch the 640×480 screen border. It also reports which sides of the ball touch either paddle. Outputs feed the t_clk movement/score logic, which permits motion on a side only while that side's "clear" bit is 1, and drive the LED bank.

---
 rtl/edge_detect_if.sv | 40 ++++
 rtl/edge_detect.sv | 84 ++++++++
 tb/tb_edge_detect.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/edge_detect_if.sv
// Geometry and detect-result bundle between the pong game logic and edge_detect.
// master drives geometry and reads results; slave is the detector side.
interface edge_detect_if #(
    parameter int W = 32
);
    logic signed [W-1:0] ball_size_x, ball_size_y;
    logic signed [W-1:0] ball_ini_x, ball_ini_y;
    logic signed [W-1:0] ball_off_x, ball_off_y;

    logic signed [W-1:0] paddle_R_size_x, paddle_R_size_y;
    logic signed [W-1:0] paddle_R_ini_x, paddle_R_ini_y;
    logic signed [W-1:0] paddle_R_off_x, paddle_R_off_y;

    logic signed [W-1:0] paddle_L_size_x, paddle_L_size_y;
    logic signed [W-1:0] paddle_L_ini_x, paddle_L_ini_y;
    logic signed [W-1:0] paddle_L_off_x, paddle_L_off_y;

    logic [3:0] ball_detect_edge;
    logic [3:0] paddle_R_detect_edge;
    logic [3:0] paddle_L_detect_edge;
    logic [7:0] collision_detect;

    modport master (
        output ball_size_x, ball_size_y, ball_ini_x, ball_ini_y, ball_off_x, ball_off_y,
        output paddle_R_size_x, paddle_R_size_y, paddle_R_ini_x, paddle_R_ini_y,
        output paddle_R_off_x, paddle_R_off_y,
        output paddle_L_size_x, paddle_L_size_y, paddle_L_ini_x, paddle_L_ini_y,
        output paddle_L_off_x, paddle_L_off_y,
        input  ball_detect_edge, paddle_R_detect_edge, paddle_L_detect_edge, collision_detect
    );

    modport slave (
        input  ball_size_x, ball_size_y, ball_ini_x, ball_ini_y, ball_off_x, ball_off_y,
        input  paddle_R_size_x, paddle_R_size_y, paddle_R_ini_x, paddle_R_ini_y,
        input  paddle_R_off_x, paddle_R_off_y,
        input  paddle_L_size_x, paddle_L_size_y, paddle_L_ini_x, paddle_L_ini_y,
        input  paddle_L_off_x, paddle_L_off_y,
        output ball_detect_edge, paddle_R_detect_edge, paddle_L_detect_edge, collision_detect
    );
endinterface

// File: rtl/edge_detect.sv
// Registered screen-border and ball/paddle contact detector for the pong game logic.
// Border bits are 1 when the side is clear to move; contact bits are 1 on touch.
module edge_detect #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int W     = 32
) (
    input  logic         t_clk,
    input  logic         reset_n,
    edge_detect_if.slave bus
);
    localparam logic signed [W-1:0] H_LIM = W'(H_RES);
    localparam logic signed [W-1:0] V_LIM = W'(V_RES);
    localparam logic signed [W-1:0] ZERO  = '0;

    logic signed [W-1:0] b_x0, b_y0, b_x1, b_y1;
    logic signed [W-1:0] r_x0, r_y0, r_x1, r_y1;
    logic signed [W-1:0] l_x0, l_y0, l_x1, l_y1;
    logic                h_ok_r, v_ok_r, h_ok_l, v_ok_l;
    logic [3:0]          ball_border, r_border, l_border;
    logic [3:0]          hit_r, hit_l;

    assign b_x0 = bus.ball_ini_x + bus.ball_off_x;
    assign b_y0 = bus.ball_ini_y + bus.ball_off_y;
    assign b_x1 = b_x0 + bus.ball_size_x;
    assign b_y1 = b_y0 + bus.ball_size_y;

    assign r_x0 = bus.paddle_R_ini_x + bus.paddle_R_off_x;
    assign r_y0 = bus.paddle_R_ini_y + bus.paddle_R_off_y;
    assign r_x1 = r_x0 + bus.paddle_R_size_x;
    assign r_y1 = r_y0 + bus.paddle_R_size_y;

    assign l_x0 = bus.paddle_L_ini_x + bus.paddle_L_off_x;
    assign l_y0 = bus.paddle_L_ini_y + bus.paddle_L_off_y;
    assign l_x1 = l_x0 + bus.paddle_L_size_x;
    assign l_y1 = l_y0 + bus.paddle_L_size_y;

    // Degenerate rectangles can satisfy the interval tests, so overlap needs positive sizes.
    assign h_ok_r = (bus.ball_size_x > ZERO) && (bus.paddle_R_size_x > ZERO);
    assign v_ok_r = (bus.ball_size_y > ZERO) && (bus.paddle_R_size_y > ZERO);
    assign h_ok_l = (bus.ball_size_x > ZERO) && (bus.paddle_L_size_x > ZERO);
    assign v_ok_l = (bus.ball_size_y > ZERO) && (bus.paddle_L_size_y > ZERO);

    // Result order {left, top, right, bottom}.
    function automatic logic [3:0] border(
        input logic signed [W-1:0] x0, y0, x1, y1
    );
        border = {x0 > ZERO, y0 > ZERO, x1 < H_LIM, y1 < V_LIM};
    endfunction

    function automatic logic [3:0] contact(
        input logic signed [W-1:0] bx0, by0, bx1, by1,
        input logic signed [W-1:0] px0, py0, px1, py1,
        input logic                h_ok, v_ok
    );
        logic hov, vov;
        hov = h_ok && (bx0 < px1) && (px0 < bx1);
        vov = v_ok && (by0 < py1) && (py0 < by1);
        contact[0] = hov && (by1 >= py0) && (by0 < py0);
        contact[1] = vov && (bx1 >= px0) && (bx0 < px0);
        contact[2] = hov && (by0 <= py1) && (by1 > py1);
        contact[3] = vov && (bx0 <= px1) && (bx1 > px1);
    endfunction

    assign ball_border = border(b_x0, b_y0, b_x1, b_y1);
    assign r_border    = border(r_x0, r_y0, r_x1, r_y1);
    assign l_border    = border(l_x0, l_y0, l_x1, l_y1);
    assign hit_r = contact(b_x0, b_y0, b_x1, b_y1, r_x0, r_y0, r_x1, r_y1, h_ok_r, v_ok_r);
    assign hit_l = contact(b_x0, b_y0, b_x1, b_y1, l_x0, l_y0, l_x1, l_y1, h_ok_l, v_ok_l);

    always_ff @(posedge t_clk) begin
        if (!reset_n) begin
            bus.ball_detect_edge     <= 4'b1111;
            bus.paddle_R_detect_edge <= 4'b1111;
            bus.paddle_L_detect_edge <= 4'b1111;
            bus.collision_detect     <= 8'h00;
        end else begin
            bus.ball_detect_edge     <= ball_border;
            bus.paddle_R_detect_edge <= r_border;
            bus.paddle_L_detect_edge <= l_border;
            bus.collision_detect     <= {hit_l, hit_r};
        end
    end
endmodule

// File: tb/tb_edge_detect.sv
// Bench for edge_detect: directed vector table, multi-cycle sequences and
// randomized geometry checked against a rectangle-level reference model.
module tb_edge_detect;
    logic t_clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    edge_detect_if #(.W(32)) bus ();
    edge_detect #(.H_RES(640), .V_RES(480), .W(32)) dut (
        .t_clk   (t_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 t_clk = ~t_clk;

    // Geometry layout per object: size_x, size_y, ini_x, ini_y, off_x, off_y; ball, R, L.
    typedef int geom_t[18];

    typedef struct {
        int         b_sx, b_sy, b_ox, b_oy, r_oy, l_oy;
        logic [3:0] eb, er, el;
        logic [7:0] ec;
    } vec_t;

    geom_t base = '{25, 25, 269, 189, 0, 0,
                    10, 150, 600, 100, 0, 0,
                    10, 150, 40, 189, 0, 0};

    task automatic drive(input geom_t v);
        bus.ball_size_x     = v[0];  bus.ball_size_y     = v[1];
        bus.ball_ini_x      = v[2];  bus.ball_ini_y      = v[3];
        bus.ball_off_x      = v[4];  bus.ball_off_y      = v[5];
        bus.paddle_R_size_x = v[6];  bus.paddle_R_size_y = v[7];
        bus.paddle_R_ini_x  = v[8];  bus.paddle_R_ini_y  = v[9];
        bus.paddle_R_off_x  = v[10]; bus.paddle_R_off_y  = v[11];
        bus.paddle_L_size_x = v[12]; bus.paddle_L_size_y = v[13];
        bus.paddle_L_ini_x  = v[14]; bus.paddle_L_ini_y  = v[15];
        bus.paddle_L_off_x  = v[16]; bus.paddle_L_off_y  = v[17];
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] eb, input logic [3:0] er,
                           input logic [3:0] el, input logic [7:0] ec);
        chk({tag, " ball_edge"}, {4'h0, bus.ball_detect_edge}, {4'h0, eb});
        chk({tag, " padR_edge"}, {4'h0, bus.paddle_R_detect_edge}, {4'h0, er});
        chk({tag, " padL_edge"}, {4'h0, bus.paddle_L_detect_edge}, {4'h0, el});
        chk({tag, " collision"}, bus.collision_detect, ec);
    endtask

    // Reference model: rectangles (x0,x1] x (y0,y1]; sides as interval membership.
    function automatic void model(input geom_t v, output logic [3:0] eb, output logic [3:0] er,
                                  output logic [3:0] el, output logic [7:0] ec);
        int x0[3], y0[3], x1[3], y1[3], sx[3], sy[3];
        logic [3:0] side[3];
        logic [3:0] hit[2];
        for (int o = 0; o < 3; o++) begin
            sx[o] = v[o*6];
            sy[o] = v[o*6+1];
            x0[o] = v[o*6+2] + v[o*6+4];
            y0[o] = v[o*6+3] + v[o*6+5];
            x1[o] = x0[o] + sx[o];
            y1[o] = y0[o] + sy[o];
            side[o][0] = y1[o] < 480;
            side[o][1] = x1[o] < 640;
            side[o][2] = y0[o] > 0;
            side[o][3] = x0[o] > 0;
        end
        for (int p = 1; p < 3; p++) begin
            bit hov, vov;
            hov = sx[0] > 0 && sx[p] > 0 && x0[0] < x1[p] && x0[p] < x1[0];
            vov = sy[0] > 0 && sy[p] > 0 && y0[0] < y1[p] && y0[p] < y1[0];
            // Paddle's near edge lies in the ball's span, ball's far edge not past it.
            hit[p-1][0] = hov && y0[p] > y0[0] && y0[p] <= y1[0];
            hit[p-1][1] = vov && x0[p] > x0[0] && x0[p] <= x1[0];
            hit[p-1][2] = hov && y1[p] >= y0[0] && y1[p] < y1[0];
            hit[p-1][3] = vov && x1[p] >= x0[0] && x1[p] < x1[0];
        end
        eb = side[0];
        er = side[1];
        el = side[2];
        ec = {hit[1], hit[0]};
    endfunction

    vec_t vecs[12];

    initial begin
        geom_t v;
        logic [3:0] eb, er, el;
        logic [7:0] ec;

        vecs[0]  = '{25, 25,    0,    0,   0,    0, 4'hF, 4'hF, 4'hF, 8'h00};
        vecs[1]  = '{25, 25,    0,  265,   0,    0, 4'hF, 4'hF, 4'hF, 8'h00};
        vecs[2]  = '{25, 25,    0,  266,   0,    0, 4'hE, 4'hF, 4'hF, 8'h00};
        vecs[3]  = '{25, 25, -269,    0,   0,    0, 4'h7, 4'hF, 4'hF, 8'h00};
        vecs[4]  = '{25, 25, -268,    0,   0,    0, 4'hF, 4'hF, 4'hF, 8'h00};
        vecs[5]  = '{25, 25,  306,    0,   0,    0, 4'hF, 4'hF, 4'hF, 8'h02};
        vecs[6]  = '{25, 25,    0,    0,   0, -189, 4'hF, 4'hF, 4'hB, 8'h00};
        vecs[7]  = '{25, 25,    0,    0, 230,    0, 4'hF, 4'hE, 4'hF, 8'h00};
        vecs[8]  = '{25, 25, -244,    0,   0,    0, 4'hF, 4'hF, 4'hF, 8'h20};
        vecs[9]  = '{25, 25, -219,    0,   0,    0, 4'hF, 4'hF, 4'hF, 8'h80};
        vecs[10] = '{25,  0,  306,    0,   0,    0, 4'hF, 4'hF, 4'hF, 8'h00};
        vecs[11] = '{25, 25,  336, -114,   0,    0, 4'hF, 4'hF, 4'hF, 8'h01};

        // Reset with non-default geometry forces the idle values.
        reset_n = 1'b0;
        v = base; v[5] = 266; v[4] = 306;
        drive(v);
        @(posedge t_clk); #1;
        chk_all("reset", 4'hF, 4'hF, 4'hF, 8'h00);

        @(negedge t_clk);
        reset_n = 1'b1;
        drive(base);
        @(posedge t_clk); #1;
        chk_all("default", 4'hF, 4'hF, 4'hF, 8'h00);

        foreach (vecs[i]) begin
            @(negedge t_clk);
            v = base;
            v[0] = vecs[i].b_sx; v[1] = vecs[i].b_sy;
            v[4] = vecs[i].b_ox; v[5] = vecs[i].b_oy;
            v[11] = vecs[i].r_oy; v[17] = vecs[i].l_oy;
            drive(v);
            @(posedge t_clk); #1;
            chk_all($sformatf("vec%0d", i), vecs[i].eb, vecs[i].er, vecs[i].el, vecs[i].ec);
        end

        // Output must hold until the next edge after an input change.
        @(negedge t_clk);
        v = base; v[5] = 266; drive(v);
        @(posedge t_clk); #1;
        chk_all("lat_a", 4'hE, 4'hF, 4'hF, 8'h00);
        @(negedge t_clk);
        v[5] = 265; drive(v);
        #1;
        chk_all("lat_hold", 4'hE, 4'hF, 4'hF, 8'h00);
        @(posedge t_clk); #1;
        chk_all("lat_b", 4'hF, 4'hF, 4'hF, 8'h00);

        // Mid-operation reset overrides an active contact, then it reappears.
        @(negedge t_clk);
        v = base; v[4] = 306; drive(v);
        @(posedge t_clk); #1;
        chk_all("pre_rst", 4'hF, 4'hF, 4'hF, 8'h02);
        @(negedge t_clk);
        reset_n = 1'b0;
        @(posedge t_clk); #1;
        chk_all("mid_rst", 4'hF, 4'hF, 4'hF, 8'h00);
        @(negedge t_clk);
        reset_n = 1'b1;
        @(posedge t_clk); #1;
        chk_all("post_rst", 4'hF, 4'hF, 4'hF, 8'h02);

        for (int n = 0; n < 400; n++) begin
            int d;
            @(negedge t_clk);
            v = base;
            d = int'($urandom_range(0, 6)) - 3;
            case ($urandom_range(0, 3))
                0: begin
                    for (int k = 0; k < 18; k++) begin
                        if (k % 6 < 2)      v[k] = int'($urandom_range(0, 60)) - 5;
                        else if (k % 6 < 4) v[k] = int'($urandom_range(0, 640));
                        else                v[k] = int'($urandom_range(0, 600)) - 300;
                    end
                end
                1: begin
                    v[4] = 306 + d;
                    v[5] = int'($urandom_range(0, 260)) - 150;
                    v[1] = int'($urandom_range(0, 30)) - 2;
                end
                2: begin
                    v[4] = ($urandom_range(0, 1) == 0) ? -219 + d : -244 + d;
                    v[5] = int'($urandom_range(0, 300)) - 40;
                    v[0] = int'($urandom_range(0, 30)) - 2;
                end
                default: begin
                    v[4] = 336 + int'($urandom_range(0, 10)) - 5;
                    v[5] = ($urandom_range(0, 1) == 0) ? -114 + d : 36 + d;
                    v[11] = int'($urandom_range(0, 460)) - 230;
                    v[17] = int'($urandom_range(0, 480)) - 240;
                end
            endcase
            drive(v);
            model(v, eb, er, el, ec);
            @(posedge t_clk); #1;
            chk_all($sformatf("rand%0d", n), eb, er, el, ec);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
